wb_fetch_unit: RTL and testbench

// - Instruction fetch front end of copperv. Wishbone classic master on the

---
 rtl/wb_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_wb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fetch_unit.sv
// Instruction fetch front end: Wishbone classic single-word reads from a
// sequential PC, buffered with their PC in a small FIFO for decode.
// Ports: clk, rst (async, active high); redirect_valid/redirect_pc load a
// new PC and flush; inst_valid/inst_ready/inst_data/inst_pc feed decode;
// adr/datwr/we/sel/stb/cyc/ack/datrd form the Wishbone master.
module wb_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [DATA_WIDTH-1:0]   inst_data,
  output logic [ADDR_WIDTH-1:0]   inst_pc,
  output logic [ADDR_WIDTH-1:0]   adr,
  output logic [DATA_WIDTH-1:0]   datwr,
  output logic                    we,
  output logic [DATA_WIDTH/8-1:0] sel,
  output logic                    stb,
  output logic                    cyc,
  input  logic                    ack,
  input  logic [DATA_WIDTH-1:0]   datrd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] pc, pc_n, adr_n;
  logic [ADDR_WIDTH-1:0] target;
  logic                  stb_n;
  logic                  push, pop, space;

  logic [ADDR_WIDTH-1:0] fifo_pc  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_dat [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;

  assign datwr = '0;
  assign we    = 1'b0;
  assign sel   = '1;
  assign cyc   = stb;

  assign target = redirect_pc & ~ADDR_WIDTH'(3);
  assign space  = count < CW'(FIFO_DEPTH);

  assign inst_valid = count != '0;
  assign inst_data  = fifo_dat[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

  // Redirect flushes the FIFO, so it also cancels a same-cycle pop.
  assign pop = inst_valid & inst_ready;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    adr_n   = adr;
    stb_n   = stb;
    push    = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          pc_n = target;
        end else if (space) begin
          stb_n   = 1'b1;
          adr_n   = pc;
          state_n = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          stb_n   = 1'b0;
          state_n = IDLE;
          push    = !redirect_valid;
          pc_n    = redirect_valid ? target
                                   : pc + ADDR_WIDTH'(4);
        end else if (redirect_valid) begin
          // The bus cycle must still complete; its data is stale.
          pc_n    = target;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_n = target;
        if (ack) begin
          stb_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      adr   <= '0;
      stb   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      adr   <= adr_n;
      stb   <= stb_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]  <= adr;
      fifo_dat[wr_ptr] <= datrd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_fetch_unit.sv
// Bench for wb_fetch_unit: directed scenarios plus random traffic, checked
// against an expected-instruction-stream model of the fetch unit.
module tb_wb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] adr;
  logic [31:0] datwr;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        ack = 1'b0;
  logic [31:0] datrd = '0;

  wb_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .adr            (adr),
    .datwr          (datwr),
    .we             (we),
    .sel            (sel),
    .stb            (stb),
    .cyc            (cyc),
    .ack            (ack),
    .datrd          (datrd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: words fetched but not yet consumed, as {pc, data}.
  logic [63:0] q[$];
  logic [31:0] exp_fetch;
  logic        stale;
  int          reads;
  int          ndel;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; drives one cycle and checks after
  // the next edge.
  task automatic step(input logic rv, input logic [31:0] rpc,
                      input logic rdy, input logic ak);
    logic        pre_stb, acked;
    logic [31:0] pre_adr;
    int          pre_cnt;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    ack            = ak;
    datrd          = adr + 32'd1;
    pre_stb = stb;
    pre_adr = adr;
    pre_cnt = q.size();
    acked   = stb && ak;
    if (acked && !stale) check("ack_adr", adr, exp_fetch);
    if (q.size() != 0 && rdy && !rv) begin
      void'(q.pop_front());
      ndel++;
    end
    if (acked && !stale && !rv) begin
      q.push_back({exp_fetch, exp_fetch + 32'd1});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (acked) stale = 1'b0;
    if (rv) begin
      q.delete();
      exp_fetch = rpc & ~32'd3;
      if (stb && !ak) stale = 1'b1;
    end
    @(posedge clk);
    #1;
    check("valid", inst_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("inst_pc", inst_pc, q[0][63:32]);
      check("inst_data", inst_data, q[0][31:0]);
    end
    check("cyc", cyc, stb);
    if (acked) begin
      check("gap", stb, 0);
    end else if (pre_stb) begin
      check("hold_stb", stb, 1);
      check("hold_adr", adr, pre_adr);
    end
    if (stb && !pre_stb) begin
      reads++;
      check("issue_adr", adr, exp_fetch);
      check("issue_room", pre_cnt < 2, 1);
      check("issue_redir", rv, 0);
    end
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, stb);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    ack = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_stb", stb, 0);
    check("rst_cyc", cyc, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_adr", adr, 0);
    q.delete();
    exp_fetch = 32'h0;
    stale = 1'b0;
    reads = 0;
    ndel = 0;
    rst = 1'b0;
  endtask

  initial begin
    int  hits;
    logic rv;
    logic [31:0] rpc;

    // Reset and first request
    do_reset();
    check("we", we, 0);
    check("sel", sel, 4'hF);
    check("datwr", datwr, 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("rel_stb", stb, 1);
    check("rel_adr", adr, 0);

    // Sequential fetch
    do_reset();
    run(30, 1'b1);
    check("seq_delivered", ndel >= 3, 1);

    // Backpressure
    do_reset();
    run(20, 1'b0);
    check("bp_reads", reads, 2);
    check("bp_idle", stb, 0);
    hits = 0;
    for (int i = 0; i < 10 && hits == 0; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (stb) hits = 1;
    end
    check("bp_resume", hits, 1);
    check("bp_resume_adr", adr, 32'h8);

    // Redirect while idle with a full FIFO
    do_reset();
    run(20, 1'b0);
    step(1'b1, 32'h100, 1'b0, 1'b0);
    check("flush", inst_valid, 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("redir_stb", stb, 1);
    check("redir_adr", adr, 32'h100);
    run(10, 1'b1);

    // Redirect while the read of 0x8 is outstanding
    do_reset();
    hits = 0;
    for (int i = 0; i < 40 && hits == 0; i++) begin
      step(1'b0, '0, 1'b1, stb);
      if (stb && adr == 32'h8) hits = 1;
    end
    check("mid_reach8", hits, 1);
    step(1'b1, 32'h200, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    hits = 0;
    for (int i = 0; i < 10 && hits == 0; i++) begin
      step(1'b0, '0, 1'b1, stb);
      if (stb) hits = 1;
    end
    check("mid_next_adr", adr, 32'h200);

    // Wrap of the PC, with unaligned redirect bits
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    hits = 0;
    for (int i = 0; i < 20 && hits == 0; i++) begin
      step(1'b0, '0, 1'b1, stb);
      if (stb && adr == 32'h0) hits = 1;
    end
    check("wrap_adr0", hits, 1);

    // Reset while a read is in flight
    check("pre_rst_stb", stb, 1);
    rst = 1'b1;
    #1;
    check("async_stb", stb, 0);
    check("async_cyc", cyc, 0);
    do_reset();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        rpc = $urandom;
      step(rv, rpc, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0));
    end
    check("rand_progress", ndel > 50, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
